// File: rtl/wb_trace_buffer_if.sv
// Write-back trace port: WB-stage capture inputs, head-of-FIFO read side and status.
// The CPU tap plus consumer drive the master side; the trace buffer is the slave.
interface wb_trace_buffer_if #(
    parameter int ADDR_W = 4
);
    logic              wb_valid;
    logic [31:0]       wb_pc;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [31:0]       rd_pc;
    logic [4:0]        rd_addr;
    logic [31:0]       rd_data;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        dropped;
    logic              stopped;

    modport master (
        output wb_valid, wb_pc, wb_addr, wb_data, rd_ready,
        input  rd_valid, rd_pc, rd_addr, rd_data, count, overflow, dropped, stopped
    );

    modport slave (
        input  wb_valid, wb_pc, wb_addr, wb_data, rd_ready,
        output rd_valid, rd_pc, rd_addr, rd_data, count, overflow, dropped, stopped
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Captures register-file writes (pc, rd, data) into a FIFO; visible 1 cycle after capture.
// Full FIFO drops new writes (counted) unless a pop frees the slot that same cycle.
module wb_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int STOP_AFTER = 0
) (
    input  logic                clk,
    input  logic                rst,
    wb_trace_buffer_if.slave    bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {
        CAPTURE = 1'b0,
        STOPPED = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     STOP_CNT = 32'(STOP_AFTER);

    entry_t            mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       total;
    logic              overflow_q;
    logic [7:0]        dropped_q;
    logic              stopped_q;

    logic cand;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign cand = bus.wb_valid && (bus.wb_addr != 5'd0) && (state == CAPTURE);
    assign full = (cnt == FULL_CNT);
    assign pop  = (cnt != '0) && bus.rd_ready;
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    // Storage is deliberately left out of reset; rd_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: bus.wb_pc, addr: bus.wb_addr, data: bus.wb_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            total      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 8'd0;
            stopped_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                total  <= total + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != 8'hFF) begin
                    dropped_q <= dropped_q + 8'd1;
                end
            end
            case (state)
                CAPTURE: begin
                    if ((STOP_CNT != 32'd0) && push && (total + 32'd1 == STOP_CNT)) begin
                        state     <= STOPPED;
                        stopped_q <= 1'b1;
                    end
                end
                STOPPED: begin
                    state <= STOPPED;
                end
                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

    assign bus.rd_valid = (cnt != '0);
    assign bus.rd_pc    = mem[rd_ptr].pc;
    assign bus.rd_addr  = mem[rd_ptr].addr;
    assign bus.rd_data  = mem[rd_ptr].data;
    assign bus.count    = cnt;
    assign bus.overflow = overflow_q;
    assign bus.dropped  = dropped_q;
    assign bus.stopped  = stopped_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: one free-running instance and one with STOP_AFTER=4.
module tb_wb_trace_buffer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wb_trace_buffer_if #(.ADDR_W(4)) m ();
    wb_trace_buffer_if #(.ADDR_W(4)) s ();

    wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_AFTER(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_AFTER(4)) u_dut_stop (
        .clk (clk),
        .rst (rst),
        .bus (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        m.wb_valid = 1'b0; m.wb_pc = '0; m.wb_addr = '0; m.wb_data = '0; m.rd_ready = 1'b0;
        s.wb_valid = 1'b0; s.wb_pc = '0; s.wb_addr = '0; s.wb_data = '0; s.rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_count",    32'(m.count), 32'd0);
        check("rst_rd_valid", 32'(m.rd_valid), 32'd0);
        check("rst_overflow", 32'(m.overflow), 32'd0);
        check("rst_dropped",  32'(m.dropped), 32'd0);
        check("rst_stopped",  32'(s.stopped), 32'd0);

        // single write becomes visible one cycle later
        m.wb_valid = 1'b1; m.wb_addr = 5'd8; m.wb_data = 32'h1234; m.wb_pc = 32'h0;
        tick();
        m.wb_valid = 1'b0;
        check("t1_rd_valid", 32'(m.rd_valid), 32'd1);
        check("t1_rd_addr",  32'(m.rd_addr), 32'd8);
        check("t1_rd_data",  m.rd_data, 32'h1234);
        check("t1_rd_pc",    m.rd_pc, 32'h0);
        check("t1_count",    32'(m.count), 32'd1);
        m.rd_ready = 1'b1;
        tick();
        m.rd_ready = 1'b0;
        check("t1_drained", 32'(m.count), 32'd0);

        // writes to x0 are ignored
        m.wb_valid = 1'b1; m.wb_addr = 5'd0; m.wb_data = 32'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_count",    32'(m.count), 32'd0);
            check("t2_rd_valid", 32'(m.rd_valid), 32'd0);
        end
        m.wb_valid = 1'b0;
        check("t2_overflow", 32'(m.overflow), 32'd0);

        // DEPTH+3 writes without draining: three drops
        for (int i = 0; i < 19; i++) begin
            m.wb_valid = 1'b1; m.wb_addr = 5'((i % 31) + 1); m.wb_data = 32'(i); m.wb_pc = 32'(i * 4);
            tick();
        end
        m.wb_valid = 1'b0;
        check("t3_count",    32'(m.count), 32'd16);
        check("t3_overflow", 32'(m.overflow), 32'd1);
        check("t3_dropped",  32'(m.dropped), 32'd3);
        m.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain_vld",  32'(m.rd_valid), 32'd1);
            check("t3_drain_data", m.rd_data, 32'(i));
            check("t3_drain_pc",   m.rd_pc, 32'(i * 4));
            tick();
        end
        m.rd_ready = 1'b0;
        check("t3_empty", 32'(m.rd_valid), 32'd0);

        // full FIFO: simultaneous pop and push keeps count at DEPTH
        for (int i = 0; i < 16; i++) begin
            m.wb_valid = 1'b1; m.wb_addr = 5'd5; m.wb_data = 32'h100 + 32'(i);
            tick();
        end
        check("t4_full", 32'(m.count), 32'd16);
        check("t4_head", m.rd_data, 32'h100);
        m.rd_ready = 1'b1; m.wb_data = 32'hAA;
        tick();
        m.wb_valid = 1'b0;
        check("t4_count",   32'(m.count), 32'd16);
        check("t4_dropped", 32'(m.dropped), 32'd3);
        for (int i = 0; i < 16; i++) begin
            check("t4_drain_data", m.rd_data, (i < 15) ? (32'h101 + 32'(i)) : 32'hAA);
            tick();
        end
        m.rd_ready = 1'b0;
        check("t4_empty", 32'(m.count), 32'd0);

        // stop after four captured writes
        for (int i = 0; i < 6; i++) begin
            s.wb_valid = 1'b1; s.wb_addr = 5'd9; s.wb_data = 32'h200 + 32'(i);
            tick();
            check("t5_stopped", 32'(s.stopped), (i >= 3) ? 32'd1 : 32'd0);
        end
        s.wb_valid = 1'b0;
        check("t5_count",    32'(s.count), 32'd4);
        check("t5_dropped",  32'(s.dropped), 32'd0);
        check("t5_overflow", 32'(s.overflow), 32'd0);
        s.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_drain_data", s.rd_data, 32'h200 + 32'(i));
            tick();
        end
        s.rd_ready = 1'b0;
        check("t5_empty",      32'(s.rd_valid), 32'd0);
        check("t5_still_stop", 32'(s.stopped), 32'd1);

        // mid-run reset clears everything, capture resumes
        for (int i = 0; i < 7; i++) begin
            m.wb_valid = 1'b1; m.wb_addr = 5'd2; m.wb_data = 32'(i);
            tick();
        end
        m.wb_valid = 1'b0;
        check("t6_pre_count",    32'(m.count), 32'd7);
        check("t6_pre_overflow", 32'(m.overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count",    32'(m.count), 32'd0);
        check("t6_rd_valid", 32'(m.rd_valid), 32'd0);
        check("t6_overflow", 32'(m.overflow), 32'd0);
        check("t6_dropped",  32'(m.dropped), 32'd0);
        check("t6_stopped",  32'(s.stopped), 32'd0);
        m.wb_valid = 1'b1; m.wb_addr = 5'd3; m.wb_data = 32'h77; m.wb_pc = 32'h40;
        s.wb_valid = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'h78;
        tick();
        m.wb_valid = 1'b0;
        s.wb_valid = 1'b0;
        check("t6_new_valid", 32'(m.rd_valid), 32'd1);
        check("t6_new_data",  m.rd_data, 32'h77);
        check("t6_new_pc",    m.rd_pc, 32'h40);
        check("t6_new_count", 32'(m.count), 32'd1);
        check("t6_stop_cap",  s.rd_data, 32'h78);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
